// File: rtl/fpga_skeleton_pkg.sv
// Shared sizes, FSM encoding and element types for the matrix-multiply skeleton.
// Index helper maps (row, col) onto the row-major flat storage index.
package fpga_skeleton_pkg;

    localparam int DIM_N        = 3;
    localparam int DW           = 16;
    localparam int ODW          = 2*DW + $clog2(DIM_N) + 1;
    localparam int AW           = $clog2(2*DIM_N*DIM_N);
    localparam int NN           = DIM_N*DIM_N;
    localparam int CW           = (NN > 1) ? $clog2(NN) : 1;
    localparam int IW           = (DIM_N > 1) ? $clog2(DIM_N) : 1;
    localparam int CLK_HALF_PRD = 5;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    typedef logic [DW-1:0]  elem_t;
    typedef logic [ODW-1:0] res_t;
    typedef logic [IW-1:0]  idx_t;

    function automatic logic [CW-1:0] flat_idx(input idx_t r, input idx_t c);
        return CW'(r) * CW'(DIM_N) + CW'(c);
    endfunction

endpackage

// File: rtl/matmul_mac.sv
// Single multiply-accumulate lane: unsigned DW x DW product added into an ODW accumulator.
// sum_o is the running total including the current product, so the caller can capture it on the final term.
module matmul_mac
    import fpga_skeleton_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  en_i,
    input  logic  clr_i,
    input  elem_t a_i,
    input  elem_t b_i,
    output res_t  sum_o
);

    res_t            acc_q;
    res_t            acc_d;
    logic [2*DW-1:0] prod;

    assign prod  = a_i * b_i;
    assign acc_d = acc_q + res_t'(prod);
    assign sum_o = acc_d;

    // Clear wins over accumulate so the last term of a dot product restarts the sum.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
        end else if (clr_i) begin
            acc_q <= '0;
        end else if (en_i) begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/fpga_skeleton.sv
// Sequential N x N unsigned matrix multiply: host loads A and B, one MAC computes C = A*B,
// results are read back through a registered port.
module fpga_skeleton
    import fpga_skeleton_pkg::*;
(
    input  logic          clk_p,
    input  logic          clk_n,
    input  logic          rst,
    input  logic          wr_en,
    input  logic          rd_en,
    input  logic [AW-1:0] addr,
    input  elem_t         data_in,
    output res_t          count,
    output logic          busy,
    output logic          done
);

    logic   clk;
    state_t state_q;
    idx_t   i_q, j_q, k_q;
    logic   busy_q, done_q;
    res_t   i_count;
    elem_t  a_q [NN];
    elem_t  b_q [NN];
    res_t   c_q [NN];

    logic   wr_ok, start, last_i, last_j, last_k, run_q, mac_clr;
    elem_t  mac_a, mac_b;
    res_t   mac_sum;

    // Behavioural stand-in for the differential input buffer.
    assign clk = clk_p & ~clk_n;

    assign wr_ok   = wr_en && !busy_q;
    assign start   = wr_ok && (addr == AW'(2*NN-1)) && (state_q == IDLE);
    assign last_i  = (i_q == idx_t'(DIM_N-1));
    assign last_j  = (j_q == idx_t'(DIM_N-1));
    assign last_k  = (k_q == idx_t'(DIM_N-1));
    assign run_q   = (state_q == RUN);
    assign mac_clr = start || (run_q && last_k);
    assign mac_a   = a_q[flat_idx(i_q, k_q)];
    assign mac_b   = b_q[flat_idx(k_q, j_q)];

    matmul_mac u_mac (
        .clk   (clk),
        .rst   (rst),
        .en_i  (run_q),
        .clr_i (mac_clr),
        .a_i   (mac_a),
        .b_i   (mac_b),
        .sum_o (mac_sum)
    );

    generate
        for (genvar gi = 0; gi < NN; gi++) begin : g_mem
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    a_q[gi] <= '0;
                    b_q[gi] <= '0;
                end else if (wr_ok) begin
                    if (addr == AW'(gi))      a_q[gi] <= data_in;
                    if (addr == AW'(NN + gi)) b_q[gi] <= data_in;
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    c_q[gi] <= '0;
                end else if (run_q && last_k && (flat_idx(i_q, j_q) == CW'(gi))) begin
                    c_q[gi] <= mac_sum;
                end
            end
        end
    endgenerate

    // k innermost, then j, then i; the final element hands over to DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            i_q     <= '0;
            j_q     <= '0;
            k_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= RUN;
                        busy_q  <= 1'b1;
                        i_q     <= '0;
                        j_q     <= '0;
                        k_q     <= '0;
                    end
                end
                RUN: begin
                    if (!last_k) begin
                        k_q <= k_q + idx_t'(1);
                    end else begin
                        k_q <= '0;
                        if (!last_j) begin
                            j_q <= j_q + idx_t'(1);
                        end else begin
                            j_q <= '0;
                            if (!last_i) begin
                                i_q <= i_q + idx_t'(1);
                            end else begin
                                i_q     <= '0;
                                state_q <= DONE;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                            end
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            i_count <= '0;
        end else if (rd_en) begin
            i_count <= (addr < AW'(NN)) ? c_q[addr[CW-1:0]] : '0;
        end
    end

    assign count = i_count;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule

// File: tb/tb_fpga_skeleton.sv
// Randomised scoreboard bench for fpga_skeleton: reads push expected C values from a
// dot-product reference model; an independent monitor pops and compares one cycle later.
module tb_fpga_skeleton;
    import fpga_skeleton_pkg::*;

    typedef longint unsigned vec_t [2*NN];

    logic          clk_p = 1'b0;
    logic          clk_n;
    logic          rst;
    logic          wr_en;
    logic          rd_en;
    logic [AW-1:0] addr;
    elem_t         data_in;
    res_t          count;
    logic          busy;
    logic          done;

    int n_checks = 0;
    int n_fail   = 0;

    longint unsigned ma [NN];
    longint unsigned mb [NN];
    longint unsigned mc [NN];

    res_t  exp_q  [$];
    string name_q [$];

    assign clk_n = ~clk_p;
    always #CLK_HALF_PRD clk_p = ~clk_p;

    fpga_skeleton dut (
        .clk_p   (clk_p),
        .clk_n   (clk_n),
        .rst     (rst),
        .wr_en   (wr_en),
        .rd_en   (rd_en),
        .addr    (addr),
        .data_in (data_in),
        .count   (count),
        .busy    (busy),
        .done    (done)
    );

    task automatic check(input string nm, input res_t act, input res_t exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // C[i][j] = sum over k of A[i][k]*B[k][j]
    task automatic model_run();
        for (int i = 0; i < DIM_N; i++) begin
            for (int j = 0; j < DIM_N; j++) begin
                longint unsigned s = 0;
                for (int k = 0; k < DIM_N; k++) s += ma[i*DIM_N+k] * mb[k*DIM_N+j];
                mc[i*DIM_N+j] = s;
            end
        end
    endtask

    task automatic model_clear();
        for (int a = 0; a < NN; a++) begin
            ma[a] = 0;
            mb[a] = 0;
            mc[a] = 0;
        end
    endtask

    task automatic wr(input int a, input longint unsigned d, input bit accepted);
        wr_en   = 1'b1;
        addr    = AW'(a);
        data_in = DW'(d);
        if (accepted && a < 2*NN) begin
            if (a < NN) ma[a] = d;
            else        mb[a-NN] = d;
        end
        $display("write addr=%0d data=%0d accepted=%0d", a, d, accepted);
        @(posedge clk_p); #1;
        wr_en = 1'b0;
    endtask

    task automatic rd(input int a, input string nm);
        res_t e;
        e = (a < NN) ? res_t'(mc[a]) : '0;
        exp_q.push_back(e);
        name_q.push_back($sformatf("%s[%0d]", nm, a));
        rd_en = 1'b1;
        addr  = AW'(a);
        @(posedge clk_p); #1;
        rd_en = 1'b0;
    endtask

    task automatic load(input vec_t v);
        for (int a = 0; a < 2*NN; a++) wr(a, v[a], 1'b1);
    endtask

    task automatic read_all(input string nm);
        for (int a = 0; a < NN; a++) rd(a, nm);
    endtask

    task automatic wait_run(input int exp_busy, input string nm);
        int bc = 0;
        int dc = 0;
        bit seen = 0;
        for (int cyc = 0; cyc < 60 && !seen; cyc++) begin
            if (busy === 1'b1) bc++;
            if (done === 1'b1) begin
                dc++;
                seen = 1;
            end else begin
                @(posedge clk_p); #1;
            end
        end
        check({nm, "_done_seen"}, res_t'(seen), res_t'(1));
        check({nm, "_busy_len"}, res_t'(bc), res_t'(exp_busy));
        @(posedge clk_p); #1;
        check({nm, "_done_fall"}, res_t'(done), res_t'(0));
        $display("run %s: busy cycles=%0d done pulses=%0d", nm, bc, dc);
        model_run();
    endtask

    // Scoreboard monitor: every read strobe sampled at an edge yields one result after it.
    always @(posedge clk_p) begin
        if (rd_en === 1'b1 && rst === 1'b0) begin
            #2;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL rd_unexpected: got %0d expected no read", count);
            end else begin
                res_t  e;
                string nm;
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                check(nm, count, e);
                $display("read %s: count=%0d expected=%0d", nm, count, e);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t v;
        rst     = 1'b1;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        addr    = '0;
        data_in = '0;
        model_clear();
        repeat (3) @(posedge clk_p);
        #1;
        check("rst_count", count, '0);
        check("rst_busy", res_t'(busy), '0);
        check("rst_done", res_t'(done), '0);
        rst = 1'b0;
        @(posedge clk_p); #1;

        // Identity times 1..9
        for (int a = 0; a < NN; a++) begin
            v[a]      = (a / DIM_N == a % DIM_N) ? 1 : 0;
            v[NN + a] = longint'(a + 1);
        end
        load(v);
        wait_run(DIM_N*DIM_N*DIM_N, "identity");
        read_all("identity");

        for (int a = 0; a < NN; a++) begin
            v[a]      = 2;
            v[NN + a] = 3;
        end
        load(v);
        wait_run(DIM_N*DIM_N*DIM_N, "known");
        read_all("known");

        for (int a = 0; a < 2*NN; a++) v[a] = 65535;
        load(v);
        wait_run(DIM_N*DIM_N*DIM_N, "max");
        read_all("max");

        for (int r = 0; r < 2; r++) begin
            for (int a = 0; a < 2*NN; a++) v[a] = longint'($urandom_range(1, 1000));
            load(v);
            wait_run(DIM_N*DIM_N*DIM_N, "random");
            repeat (20) @(posedge clk_p);
            #1;
            read_all("random");
        end

        // Write during busy is dropped; a read mid-run sees the previous C[8].
        for (int a = 0; a < 2*NN; a++) v[a] = longint'($urandom_range(1, 1000));
        load(v);
        wr(0, 777, 1'b0);
        rd(NN - 1, "rd_during_run");
        wait_run(DIM_N*DIM_N*DIM_N - 2, "collide");
        read_all("collide");
        rd(20, "rd_out_of_range");

        // Reset in the middle of a run
        for (int a = 0; a < 2*NN; a++) v[a] = longint'($urandom_range(1, 1000));
        load(v);
        rd(4, "rd_before_rst");
        #2;
        rst = 1'b1;
        #1;
        check("midrst_count", count, '0);
        check("midrst_busy", res_t'(busy), '0);
        check("midrst_done", res_t'(done), '0);
        model_clear();
        @(posedge clk_p); #1;
        rst = 1'b0;
        rd(0, "rd_after_rst");
        begin
            int bc = 0;
            repeat (30) begin
                @(posedge clk_p); #1;
                if (busy !== 1'b0) bc++;
            end
            check("postrst_idle", res_t'(bc), '0);
        end

        repeat (3) @(posedge clk_p);
        #1;
        check("scoreboard_drained", res_t'(exp_q.size()), '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
